// File: rtl/resonator_ddc_control_pkg.sv
// Shared definitions for the resonator DDC control slice.
// Holds the per-channel stall FSM state encoding and default widths.
package resonator_ddc_control_pkg;

  localparam int unsigned NUM_CH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT  = 16;

  // Per-channel AXI-Stream stall detector state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } stall_state_e;

endpackage

// File: rtl/resonator_ddc_control_axis_stall_chan.sv
// Single-channel stall detector: counts consecutive stall cycles and
// flags BLOCKED once the run reaches the threshold.
// Ports:
//   clock, reset_n   - clock, async active-low reset
//   i_stall          - TVALID & ~TREADY for this channel
//   i_active         - enable & (threshold != 0); low forces IDLE
//   i_threshold      - stall run length that flags a block
//   o_blocked        - registered, high while in BLOCKED
//   o_enter_c        - combinational: BLOCKED is entered at the coming edge
//   o_cnt_next_c     - combinational: counter value loaded at the coming edge
module resonator_ddc_control_axis_stall_chan
  import resonator_ddc_control_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_stall,
  input  logic             i_active,
  input  logic [CNT_W-1:0] i_threshold,
  output logic             o_blocked,
  output logic             o_enter_c,
  output logic [CNT_W-1:0] o_cnt_next_c
);

  stall_state_e     r_state;
  stall_state_e     w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating increment so a long stall never wraps back under threshold
  always_comb begin
    w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // Next-state and next-count
  always_comb begin
    w_state_next = r_state;
    o_cnt_next_c = r_cnt;
    if (!i_active) begin
      w_state_next = ST_IDLE;
      o_cnt_next_c = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_stall) begin
            o_cnt_next_c = CNT_W'(1);
            w_state_next = (i_threshold == CNT_W'(1)) ? ST_BLOCKED : ST_COUNT;
          end else begin
            o_cnt_next_c = '0;
          end
        end
        ST_COUNT: begin
          if (i_stall) begin
            o_cnt_next_c = w_cnt_inc;
            // Compares against the live threshold, so a lowered threshold
            // blocks on the next stalled edge
            if (w_cnt_inc >= i_threshold) begin
              w_state_next = ST_BLOCKED;
            end
          end else begin
            w_state_next = ST_IDLE;
            o_cnt_next_c = '0;
          end
        end
        ST_BLOCKED: begin
          if (i_stall) begin
            o_cnt_next_c = w_cnt_inc;
          end else begin
            w_state_next = ST_IDLE;
            o_cnt_next_c = '0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          o_cnt_next_c = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_enter_c = (w_state_next == ST_BLOCKED) && (r_state != ST_BLOCKED);
  end

  // State, counter and registered block flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      o_blocked <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= o_cnt_next_c;
      o_blocked <= (w_state_next == ST_BLOCKED);
    end
  end

endmodule

// File: rtl/resonator_ddc_control_axis_stall_probe.sv
// AXI-Stream stall probe: one stall detector per monitored channel plus
// aggregated status (sticky block history, first blocker, longest stall).
// Ports:
//   clock, reset_n   - clock, async active-low reset
//   enable           - detection enable (level)
//   threshold        - consecutive stall cycles to flag a block; 0 disables
//   clear            - pulse, clears sticky status
//   ch_tvalid/tready - per-channel handshake taps
//   axis_block_sigs  - per-channel live block flag
//   sticky_block     - per-channel latched block history
//   first_valid/ch   - first channel to block since clear/reset
//   max_stall        - longest stall run since clear/reset
module resonator_ddc_control_axis_stall_probe
  import resonator_ddc_control_pkg::*;
#(
  parameter  int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter  int unsigned CNT_W  = CNT_W_DEFAULT,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic [NUM_CH-1:0] sticky_block,
  output logic              first_valid,
  output logic [CH_W-1:0]   first_ch,
  output logic [CNT_W-1:0]  max_stall
);

  logic [NUM_CH-1:0] w_stall;
  logic              w_active;
  logic [NUM_CH-1:0] w_enter;
  logic [CNT_W-1:0]  w_cnt_next [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_max;
  logic [CH_W-1:0]   w_first_idx;

  always_comb begin
    w_stall  = ch_tvalid & ~ch_tready;
    w_active = enable && (threshold != '0);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    resonator_ddc_control_axis_stall_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_stall      (w_stall[gi]),
      .i_active     (w_active),
      .i_threshold  (threshold),
      .o_blocked    (axis_block_sigs[gi]),
      .o_enter_c    (w_enter[gi]),
      .o_cnt_next_c (w_cnt_next[gi])
    );
  end

  // Largest counter value about to be loaded across all channels
  always_comb begin
    w_cnt_max = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (w_cnt_next[i] > w_cnt_max) begin
        w_cnt_max = w_cnt_next[i];
      end
    end
  end

  // Lowest-index channel entering BLOCKED this edge (scan down so lowest wins)
  always_comb begin
    w_first_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (w_enter[i]) begin
        w_first_idx = CH_W'(i);
      end
    end
  end

  // Aggregated status; a coincident block entry wins over clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_block <= '0;
      first_valid  <= 1'b0;
      first_ch     <= '0;
      max_stall    <= '0;
    end else begin
      sticky_block <= (clear ? '0 : sticky_block) | w_enter;
      if (clear) begin
        first_valid <= |w_enter;
        first_ch    <= w_first_idx;
      end else if (!first_valid && (|w_enter)) begin
        first_valid <= 1'b1;
        first_ch    <= w_first_idx;
      end
      if (clear || (w_cnt_max > max_stall)) begin
        max_stall <= w_cnt_max;
      end
    end
  end

endmodule

// File: tb/tb_resonator_ddc_control_axis_stall_probe.sv
// Directed bench for the AXI-Stream stall probe: a vector table for the
// single-edge behaviour plus hand sequences for enable/clear, threshold
// change, saturation and asynchronous reset.
module tb_resonator_ddc_control_axis_stall_probe;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SAT_W  = 4;
  localparam int unsigned NVEC   = 20;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [CNT_W-1:0]  threshold;
  logic              clear;
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic [NUM_CH-1:0] sticky_block;
  logic              first_valid;
  logic [1:0]        first_ch;
  logic [CNT_W-1:0]  max_stall;

  logic [SAT_W-1:0]  sat_threshold;
  logic [NUM_CH-1:0] sat_block;
  logic [NUM_CH-1:0] sat_sticky;
  logic              sat_first_valid;
  logic [1:0]        sat_first_ch;
  logic [SAT_W-1:0]  sat_max;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign sat_threshold = threshold[SAT_W-1:0];

  resonator_ddc_control_axis_stall_probe #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .threshold       (threshold),
    .clear           (clear),
    .ch_tvalid       (ch_tvalid),
    .ch_tready       (ch_tready),
    .axis_block_sigs (axis_block_sigs),
    .sticky_block    (sticky_block),
    .first_valid     (first_valid),
    .first_ch        (first_ch),
    .max_stall       (max_stall)
  );

  // Narrow-counter instance for the saturation case
  resonator_ddc_control_axis_stall_probe #(
    .NUM_CH (NUM_CH),
    .CNT_W  (SAT_W)
  ) u_sat (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .threshold       (sat_threshold),
    .clear           (clear),
    .ch_tvalid       (ch_tvalid),
    .ch_tready       (ch_tready),
    .axis_block_sigs (sat_block),
    .sticky_block    (sat_sticky),
    .first_valid     (sat_first_valid),
    .first_ch        (sat_first_ch),
    .max_stall       (sat_max)
  );

  typedef struct {
    logic              en;
    logic [CNT_W-1:0]  thr;
    logic              clr;
    logic [NUM_CH-1:0] tv;
    logic [NUM_CH-1:0] tr;
    logic [NUM_CH-1:0] eb;
    logic [NUM_CH-1:0] es;
    logic              efv;
    logic [1:0]        efch;
    logic [CNT_W-1:0]  emax;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic en, input int thr, input logic clr,
                              input logic [3:0] tv, input logic [3:0] tr,
                              input logic [3:0] eb, input logic [3:0] es,
                              input logic efv, input int efch, input int emax);
    vec_t v;
    v.en = en; v.thr = CNT_W'(thr); v.clr = clr; v.tv = tv; v.tr = tr;
    v.eb = eb; v.es = es; v.efv = efv; v.efch = 2'(efch); v.emax = CNT_W'(emax);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eb, input logic [3:0] es,
                         input logic efv, input int efch, input int emax);
    chk({tag, ".block"},  32'(axis_block_sigs), 32'(eb));
    chk({tag, ".sticky"}, 32'(sticky_block),    32'(es));
    chk({tag, ".fvalid"}, 32'(first_valid),     32'(efv));
    chk({tag, ".fch"},    32'(first_ch),        32'(efch));
    chk({tag, ".max"},    32'(max_stall),       32'(emax));
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge
  task automatic step(input logic en, input int thr, input logic clr,
                      input logic [3:0] tv, input logic [3:0] tr);
    enable    = en;
    threshold = CNT_W'(thr);
    clear     = clr;
    ch_tvalid = tv;
    ch_tready = tr;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // Stall on ch0 at threshold 4, then release
    vecs[0]  = mk(1, 4, 0, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 0, 0, 1);
    vecs[1]  = mk(1, 4, 0, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 0, 0, 2);
    vecs[2]  = mk(1, 4, 0, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 0, 0, 3);
    vecs[3]  = mk(1, 4, 0, 4'b0001, 4'b1110, 4'b0001, 4'b0001, 1, 0, 4);
    vecs[4]  = mk(1, 4, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1, 0, 4);
    // Clear, then two 3-cycle stalls on ch2 separated by one ready cycle
    vecs[5]  = mk(1, 4, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    vecs[6]  = mk(1, 4, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 1);
    vecs[7]  = mk(1, 4, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 2);
    vecs[8]  = mk(1, 4, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 3);
    vecs[9]  = mk(1, 4, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 3);
    vecs[10] = mk(1, 4, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 3);
    vecs[11] = mk(1, 4, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 3);
    vecs[12] = mk(1, 4, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 3);
    vecs[13] = mk(1, 4, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 3);
    // Clear, then ch1 and ch3 blocking on the same edge at threshold 2
    vecs[14] = mk(1, 2, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    vecs[15] = mk(1, 2, 0, 4'b1010, 4'b0101, 4'b0000, 4'b0000, 0, 0, 1);
    vecs[16] = mk(1, 2, 0, 4'b1010, 4'b0101, 4'b1010, 4'b1010, 1, 1, 2);
    vecs[17] = mk(1, 2, 0, 4'b0000, 4'b1111, 4'b0000, 4'b1010, 1, 1, 2);
    // Threshold 1 blocks on the first stalled edge; first_ch stays latched
    vecs[18] = mk(1, 1, 0, 4'b0001, 4'b1110, 4'b0001, 4'b1011, 1, 1, 2);
    vecs[19] = mk(1, 1, 0, 4'b0000, 4'b1111, 4'b0000, 4'b1011, 1, 1, 2);

    reset_n   = 1'b0;
    enable    = 1'b0;
    threshold = '0;
    clear     = 1'b0;
    ch_tvalid = '0;
    ch_tready = '1;
    #12;
    chk_all("reset", 4'b0000, 4'b0000, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      step(vecs[i].en, int'(vecs[i].thr), vecs[i].clr, vecs[i].tv, vecs[i].tr);
      chk_all($sformatf("vec%0d", i), vecs[i].eb, vecs[i].es, vecs[i].efv,
              int'(vecs[i].efch), int'(vecs[i].emax));
    end

    // Enable drop releases the block but keeps history; clear wipes it
    step(1, 2, 1, 4'b0000, 4'b1111); chk_all("en.clr0",  4'b0000, 4'b0000, 0, 0, 0);
    step(1, 2, 0, 4'b0001, 4'b1110); chk_all("en.st1",   4'b0000, 4'b0000, 0, 0, 1);
    step(1, 2, 0, 4'b0001, 4'b1110); chk_all("en.blk",   4'b0001, 4'b0001, 1, 0, 2);
    step(0, 2, 0, 4'b0001, 4'b1110); chk_all("en.off",   4'b0000, 4'b0001, 1, 0, 2);
    step(0, 2, 1, 4'b0001, 4'b1110); chk_all("en.clr",   4'b0000, 4'b0000, 0, 0, 0);
    // Clear coincident with a block entry records the entry
    step(1, 1, 1, 4'b0100, 4'b1011); chk_all("clr.win",  4'b0100, 4'b0100, 1, 2, 1);
    step(1, 1, 0, 4'b0000, 4'b1111); chk_all("clr.rel",  4'b0000, 4'b0100, 1, 2, 1);
    step(1, 1, 0, 4'b0001, 4'b1110); chk_all("clr.2nd",  4'b0001, 4'b0101, 1, 2, 1);
    step(1, 1, 1, 4'b0000, 4'b1111); chk_all("clr.end",  4'b0000, 4'b0000, 0, 0, 0);

    // Lowering the threshold mid-count blocks on the next stalled edge
    step(1, 4, 0, 4'b1000, 4'b0111); chk_all("thr.c1",   4'b0000, 4'b0000, 0, 0, 1);
    step(1, 4, 0, 4'b1000, 4'b0111); chk_all("thr.c2",   4'b0000, 4'b0000, 0, 0, 2);
    step(1, 2, 0, 4'b1000, 4'b0111); chk_all("thr.low",  4'b1000, 4'b1000, 1, 3, 3);
    step(1, 2, 1, 4'b0000, 4'b1111); chk_all("thr.end",  4'b0000, 4'b0000, 0, 0, 0);

    // Long stall: narrow counter saturates at 15 and stays blocked
    for (int i = 0; i < 40; i++) begin
      step(1, 3, 0, 4'b0001, 4'b1110);
    end
    chk_all("sat.main", 4'b0001, 4'b0001, 1, 0, 40);
    chk("sat.block",  32'(sat_block),  32'h1);
    chk("sat.sticky", 32'(sat_sticky), 32'h1);
    chk("sat.max",    32'(sat_max),    32'd15);
    step(1, 3, 1, 4'b0000, 4'b1111); chk_all("sat.end",  4'b0000, 4'b0000, 0, 0, 0);

    // Async reset between edges while ch1 is mid-count and ch0 has history
    step(1, 1, 0, 4'b0001, 4'b1110); chk_all("rst.pre",  4'b0001, 4'b0001, 1, 0, 1);
    step(1, 4, 0, 4'b0010, 4'b1101); chk_all("rst.c1",   4'b0000, 4'b0001, 1, 0, 1);
    step(1, 4, 0, 4'b0010, 4'b1101); chk_all("rst.c2",   4'b0000, 4'b0001, 1, 0, 2);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_all("rst.async", 4'b0000, 4'b0000, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Threshold 0 disables detection even with every channel stalled
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 4'b1111, 4'b0000);
    end
    chk_all("thr0", 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 4, 0, 4'b0010, 4'b1101); chk_all("resume",   4'b0000, 4'b0000, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
